// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider holding HI/LO results.
// Optional signed MULT/DIV support is enabled with `define MULDIV_SIGNED_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH:0]       acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 zdiv_q, zdiv_d;
    logic                 isdiv_q, isdiv_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dbz_q, dbz_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quo_res, rem_res;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH+1:0]     div_trial;

    assign accept = (state_q == IDLE) && start && !flush;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic res_neg_q, res_neg_d;
    logic a_neg_q, a_neg_d;
    logic [2*WIDTH-1:0] prod_raw;

    assign a_neg = op[1] & a[WIDTH-1];
    assign b_neg = op[1] & b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    always_comb begin
        res_neg_d = res_neg_q;
        a_neg_d   = a_neg_q;
        if (accept) begin
            res_neg_d = a_neg ^ b_neg;
            a_neg_d   = a_neg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_neg_q <= 1'b0;
            a_neg_q   <= 1'b0;
        end else begin
            res_neg_q <= res_neg_d;
            a_neg_q   <= a_neg_d;
        end
    end

    assign prod_raw = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign prod_res = res_neg_q ? -prod_raw : prod_raw;
    assign quo_res  = res_neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_res  = a_neg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
`else
    logic unused_op1;

    assign unused_op1 = op[1];
    assign abs_a    = a;
    assign abs_b    = b;
    assign prod_res = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign quo_res  = acc_lo_q;
    assign rem_res  = acc_hi_q[WIDTH-1:0];
`endif

    // acc_hi holds p_hi (mul) or the WIDTH+1-bit remainder (div)
    assign mul_sum   = {1'b0, acc_hi_q[WIDTH-1:0]}
                     + (acc_lo_q[0] ? {1'b0, m_q} : '0);
    assign div_sh    = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    assign div_trial = {1'b0, div_sh} - {2'b00, m_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        zdiv_d   = zdiv_q;
        isdiv_d  = isdiv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d    = 1'b0;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    isdiv_d  = op[0];
                    zdiv_d   = 1'b0;
                    if (!op[0]) begin
                        acc_lo_d = abs_b;
                        m_d      = abs_a;
                        state_d  = MUL;
                    end else if (b == '0) begin
                        acc_lo_d = a;
                        zdiv_d   = 1'b1;
                        state_d  = FINISH;
                    end else begin
                        acc_lo_d = abs_a;
                        m_d      = abs_b;
                        state_d  = DIV;
                    end
                end
            end
            MUL: begin
                acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
            end
            DIV: begin
                if (!div_trial[WIDTH+1]) begin
                    acc_hi_d = div_trial[WIDTH:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_sh;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
            end
            FINISH: begin
                if (zdiv_q) begin
                    lo_d  = '1;
                    hi_d  = acc_lo_q;
                    dbz_d = 1'b1;
                end else if (isdiv_q) begin
                    lo_d = quo_res;
                    hi_d = rem_res;
                end else begin
                    hi_d = prod_res[2*WIDTH-1:WIDTH];
                    lo_d = prod_res[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // abort keeps the architectural HI/LO state untouched
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            zdiv_q   <= 1'b0;
            isdiv_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            zdiv_q   <= zdiv_d;
            isdiv_q  <= isdiv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32).
// Signed vectors run only when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    int n, bcnt;
    bit seen;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // drives a request now, returns #1 after the accepting edge E0
    task automatic start_op(input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int bc);
        edges = 0;
        bc    = 0;
        while (!done && edges < 100) begin
            if (busy) bc++;
            tick();
            edges++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        #1;
        check("rst_out", {hi, lo}, 64'h0);
        check("rst_flags", {61'b0, busy, done, div_by_zero}, 64'h0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // MULTU max x max
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bcnt);
        check("multu_lat", n, 33);
        check("multu_busy", bcnt, 33);
        check("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check("multu_busy_lo", busy, 0);
        tick();
        check("multu_done_pulse", done, 0);

        // DIVU then back-to-back MULTU started in the done cycle
        start_op(2'b01, 32'd100, 32'd7);
        wait_done(n, bcnt);
        check("divu_lat", n, 33);
        check("divu_res", {hi, lo}, {32'd2, 32'd14});
        check("divu_dbz", div_by_zero, 0);
        start_op(2'b00, 32'd3, 32'd4);
        check("b2b_accept", busy, 1);
        wait_done(n, bcnt);
        check("b2b_lat", n, 33);
        check("b2b_res", {hi, lo}, {32'd0, 32'd12});

        // divide by zero
        start_op(2'b01, 32'h1234, 32'h0);
        wait_done(n, bcnt);
        check("dz_lat", n, 1);
        check("dz_res", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        check("dz_flag", div_by_zero, 1);

        // preload via MULTU 2x3; accepting it clears div_by_zero
        start_op(2'b00, 32'd2, 32'd3);
        check("dz_clear", div_by_zero, 0);
        wait_done(n, bcnt);
        check("pre_res", {hi, lo}, {32'd0, 32'd6});

        // flush at E10
        start_op(2'b00, 32'd5, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {busy, done}, 0);
        seen = 1'b0;
        repeat (40) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("flush_nodone", seen, 0);
        check("flush_hilo", {hi, lo}, {32'd0, 32'd6});

        // start pulsed at E5 of a busy op is ignored
        start_op(2'b00, 32'd6, 32'd7);
        repeat (4) tick();
        start_op(2'b01, 32'd9, 32'd3);
        wait_done(n, bcnt);
        check("ign_lat", n, 28);
        check("ign_res", {hi, lo}, {32'd0, 32'd42});

`ifdef MULDIV_SIGNED_EN
        start_op(2'b10, 32'hFFFF_FFFD, 32'd5);
        wait_done(n, bcnt);
        check("mult_s", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, bcnt);
        check("div_s", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bcnt);
        check("div_s_min", {hi, lo}, 64'h0000_0000_8000_0000);
`else
        start_op(2'b10, 32'hFFFF_FFFD, 32'd5);
        wait_done(n, bcnt);
        check("op10_unsigned", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

        // asynchronous reset in the middle of a DIV
        start_op(2'b01, 32'd100, 32'd7);
        repeat (5) tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'h0);
        check("arst_flags", {61'b0, busy, done, div_by_zero}, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
